pcs_chain_sequencer: RTL and testbench

//  Sequences the enables of the PCS TX->RX loopback chain: encoder, scrambler, descrambler, decoder.

---
 rtl/pcs_chain_sequencer_pkg.sv | 12 +
 rtl/sat_counter.sv | 35 +++
 rtl/pcs_chain_sequencer.sv | 164 ++++++++++++++++
 tb/tb_pcs_chain_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_chain_sequencer_pkg.sv
// Shared types for the PCS loopback chain sequencer.
package pcs_chain_sequencer_pkg;

  // Sequencer phases; the encoding is exported on o_state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } seq_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] value_o
);

  logic [WIDTH-1:0] value_q, value_d;

  // Next value: clear, else increment until all-ones is reached.
  always_comb begin
    value_d = value_q;
    if (clr_i) begin
      value_d = '0;
    end else if (inc_i && (value_q != {WIDTH{1'b1}})) begin
      value_d = value_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/pcs_chain_sequencer.sv
// Brings the encoder/scrambler/descrambler/decoder enables up in pipeline
// order, drains them in the same order, owns the bypass setting and counts
// decoded blocks. Every output comes straight from a register.
module pcs_chain_sequencer
  import pcs_chain_sequencer_pkg::*;
#(
  parameter int ENC_LAT   = 2,
  parameter int SCR_LAT   = 1,
  parameter int DESCR_LAT = 1,
  parameter int DEC_LAT   = 3,
  parameter int CNT_W     = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_bypass_req,
  input  logic             i_clear_count,
  output logic             o_enable_encoder,
  output logic             o_enable_scrambler,
  output logic             o_enable_descrambler,
  output logic             o_enable_decoder,
  output logic             o_bypass,
  output logic             o_rx_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_block_count
);

  // Offsets, in cycles after the encoder enable changes, at which each
  // downstream stage (and finally the decoder output) follows.
  localparam int T_SCR   = ENC_LAT;
  localparam int T_DESCR = T_SCR + SCR_LAT;
  localparam int T_DEC   = T_DESCR + DESCR_LAT;
  localparam int T_VAL   = T_DEC + DEC_LAT;
  localparam int CW      = $clog2(T_VAL + 1);

  localparam logic [CW-1:0] OFF_SCR   = CW'(T_SCR);
  localparam logic [CW-1:0] OFF_DESCR = CW'(T_DESCR);
  localparam logic [CW-1:0] OFF_DEC   = CW'(T_DEC);
  localparam logic [CW-1:0] OFF_VAL   = CW'(T_VAL);

  seq_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          enc_q, enc_d, scr_q, scr_d, descr_q, descr_d, dec_q, dec_d;
  logic          rxv_q, rxv_d, byp_q, byp_d, busy_q, busy_d, done_q, done_d;

  assign cnt_inc = cnt_q + CW'(1);

  // State and output registers; reset drops everything immediately.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      enc_q   <= 1'b0;
      scr_q   <= 1'b0;
      descr_q <= 1'b0;
      dec_q   <= 1'b0;
      rxv_q   <= 1'b0;
      byp_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      enc_q   <= enc_d;
      scr_q   <= scr_d;
      descr_q <= descr_d;
      dec_q   <= dec_d;
      rxv_q   <= rxv_d;
      byp_q   <= byp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Phase transitions; a simultaneous start+stop in IDLE is treated as no request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_start && !i_stop) state_d = ST_FILL;
      ST_FILL:  if (i_stop) state_d = ST_DRAIN;
                else if (cnt_inc == OFF_VAL) state_d = ST_RUN;
      ST_RUN:   if (i_stop) state_d = ST_DRAIN;
      ST_DRAIN: if (cnt_inc == OFF_VAL) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Enable sequencing: stages only rise while filling and only fall while draining.
  always_comb begin
    cnt_d   = cnt_q;
    enc_d   = enc_q;
    scr_d   = scr_q;
    descr_d = descr_q;
    dec_d   = dec_q;
    rxv_d   = rxv_q;
    byp_d   = byp_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        byp_d = i_bypass_req;
        if (i_start && !i_stop) begin
          cnt_d = '0;
          enc_d = 1'b1;
        end
      end
      ST_FILL: begin
        if (i_stop) begin
          cnt_d = '0;
          enc_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == OFF_SCR)   scr_d   = 1'b1;
          if (cnt_inc == OFF_DESCR) descr_d = 1'b1;
          if (cnt_inc == OFF_DEC)   dec_d   = 1'b1;
          if (cnt_inc == OFF_VAL)   rxv_d   = 1'b1;
        end
      end
      ST_RUN: begin
        if (i_stop) begin
          cnt_d = '0;
          enc_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_inc;
        if (cnt_inc == OFF_SCR)   scr_d   = 1'b0;
        if (cnt_inc == OFF_DESCR) descr_d = 1'b0;
        if (cnt_inc == OFF_DEC)   dec_d   = 1'b0;
        if (cnt_inc == OFF_VAL) begin
          rxv_d  = 1'b0;
          done_d = 1'b1;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_block_count (
    .clk_i   (i_clock),
    .rst_i   (i_reset),
    .inc_i   (rxv_q),
    .clr_i   (i_clear_count),
    .value_o (o_block_count)
  );

  assign o_enable_encoder     = enc_q;
  assign o_enable_scrambler   = scr_q;
  assign o_enable_descrambler = descr_q;
  assign o_enable_decoder     = dec_q;
  assign o_rx_valid           = rxv_q;
  assign o_bypass             = byp_q;
  assign o_busy               = busy_q;
  assign o_done               = done_q;
  assign o_state              = state_q;

endmodule

// File: tb/tb_pcs_chain_sequencer.sv
// Randomized and directed bench for pcs_chain_sequencer with a phase/elapsed-time reference model.
module tb_pcs_chain_sequencer;

  localparam int ENC_LAT = 2, SCR_LAT = 1, DESCR_LAT = 1, DEC_LAT = 3, CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst, start, stop, byp_req, clr;
  logic enc, scr, descr, dec, byp, rxv, busy, done;
  logic [1:0] state;
  logic [CNT_W-1:0] count;
  logic [13:0] dut_vec;

  int checks = 0;
  int failures = 0;

  pcs_chain_sequencer #(
    .ENC_LAT(ENC_LAT), .SCR_LAT(SCR_LAT), .DESCR_LAT(DESCR_LAT),
    .DEC_LAT(DEC_LAT), .CNT_W(CNT_W)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_stop(stop),
    .i_bypass_req(byp_req), .i_clear_count(clr),
    .o_enable_encoder(enc), .o_enable_scrambler(scr),
    .o_enable_descrambler(descr), .o_enable_decoder(dec),
    .o_bypass(byp), .o_rx_valid(rxv), .o_busy(busy), .o_done(done),
    .o_state(state), .o_block_count(count)
  );

  always #5 clk = ~clk;

  assign dut_vec = {enc, scr, descr, dec, byp, rxv, busy, done, state, count};

  // Reference model: phase, cycles elapsed in that phase, and which stages are on.
  // Stage k (0=enc,1=scr,2=descr,3=dec,4=rx_valid) follows the encoder by off[k] cycles.
  int off[5];
  int m_phase, m_el, m_cnt;
  bit m_on[5];
  bit m_byp, m_done;

  function automatic logic [13:0] exp_vec();
    logic [1:0] ph;
    logic [CNT_W-1:0] c;
    ph = 2'(m_phase);
    c  = CNT_W'(m_cnt);
    return {m_on[0], m_on[1], m_on[2], m_on[3], m_byp, m_on[4],
            (m_phase != 0), m_done, ph, c};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_el = 0; m_cnt = 0; m_byp = 0; m_done = 0;
    for (int k = 0; k < 5; k++) m_on[k] = 0;
  endtask

  task automatic model_step(input bit s, input bit p, input bit b, input bit c);
    bit old_rxv;
    old_rxv = m_on[4];
    m_done = 0;
    case (m_phase)
      0: begin
        m_byp = b;
        if (s && !p) begin m_phase = 1; m_el = 0; m_on[0] = 1; end
      end
      1: begin
        if (p) begin m_phase = 3; m_el = 0; m_on[0] = 0; end
        else begin
          m_el++;
          for (int k = 1; k < 5; k++) if (m_el >= off[k]) m_on[k] = 1;
          if (m_el == off[4]) m_phase = 2;
        end
      end
      2: if (p) begin m_phase = 3; m_el = 0; m_on[0] = 0; end
      default: begin
        m_el++;
        for (int k = 1; k < 5; k++) if (m_el >= off[k]) m_on[k] = 0;
        if (m_el == off[4]) begin m_phase = 0; m_done = 1; end
      end
    endcase
    if (c) m_cnt = 0;
    else if (old_rxv && m_cnt < CNT_MAX) m_cnt++;
  endtask

  // Drive inputs, take one clock edge, advance the model, settle before sampling.
  task automatic tick(input bit s, input bit p, input bit b, input bit c);
    start = s; stop = p; byp_req = b; clr = c;
    @(posedge clk);
    model_step(s, p, b, c);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; start = 0; stop = 0; byp_req = 0; clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_vec !== 14'h0) begin
      failures++;
      $display("FAIL reset got=%h exp=%h", dut_vec, 14'h0);
    end
    rst = 0;
    $display("test_reset done");
  endtask

  task automatic test_start_fill();
    int first_scr, first_dec, first_rxv;
    first_scr = -1; first_dec = -1; first_rxv = -1;
    for (int k = 1; k <= 10; k++) begin
      tick(k == 1, 0, 0, 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL start_fill cyc=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
      if (first_scr < 0 && scr) first_scr = k;
      if (first_dec < 0 && dec) first_dec = k;
      if (first_rxv < 0 && rxv) first_rxv = k;
    end
    checks++;
    if (first_scr != 3 || first_dec != 5 || first_rxv != 8) begin
      failures++;
      $display("FAIL start_timing got scr=%0d dec=%0d rxv=%0d exp scr=3 dec=5 rxv=8",
               first_scr, first_dec, first_rxv);
    end
    checks++;
    if (state !== 2'd2) begin
      failures++;
      $display("FAIL run_state got=%0d exp=2", state);
    end
    $display("test_start_fill done");
  endtask

  task automatic test_stop_drain();
    int enc_off, descr_off, rxv_off, done_at;
    enc_off = -1; descr_off = -1; rxv_off = -1; done_at = -1;
    for (int k = 1; k <= 10; k++) begin
      tick(0, k == 1, 0, 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL stop_drain cyc=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
      if (enc_off < 0 && !enc) enc_off = k;
      if (descr_off < 0 && !descr) descr_off = k;
      if (rxv_off < 0 && !rxv) rxv_off = k;
      if (done_at < 0 && done) done_at = k;
    end
    checks++;
    if (enc_off != 1 || descr_off != 4 || rxv_off != 8 || done_at != 8) begin
      failures++;
      $display("FAIL drain_timing got enc=%0d descr=%0d rxv=%0d done=%0d exp 1 4 8 8",
               enc_off, descr_off, rxv_off, done_at);
    end
    $display("test_stop_drain done");
  endtask

  task automatic test_fill_stop();
    bit saw_late;
    saw_late = 0;
    for (int k = 1; k <= 11; k++) begin
      tick(k == 1, k == 2, 0, 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL fill_stop cyc=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
      if (scr || descr || dec || rxv) saw_late = 1;
    end
    checks++;
    if (saw_late || state !== 2'd0) begin
      failures++;
      $display("FAIL fill_stop_result got late_enable=%0b state=%0d exp 0 0", saw_late, state);
    end
    $display("test_fill_stop done");
  endtask

  task automatic test_bypass();
    for (int k = 1; k <= 9; k++) tick(k == 1, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      tick(0, 0, k[0], 0);
      checks++;
      if (byp !== 1'b0 || dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL bypass_run cyc=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
    end
    for (int k = 1; k <= 8; k++) tick(0, k == 1, 1, 0);
    checks++;
    if (state !== 2'd0 || byp !== 1'b0) begin
      failures++;
      $display("FAIL bypass_idle_entry got state=%0d byp=%0b exp 0 0", state, byp);
    end
    tick(0, 0, 1, 0);
    checks++;
    if (byp !== 1'b1 || dut_vec !== exp_vec()) begin
      failures++;
      $display("FAIL bypass_follow got=%h exp=%h", dut_vec, exp_vec());
    end
    tick(0, 0, 0, 0);
    checks++;
    if (byp !== 1'b0) begin
      failures++;
      $display("FAIL bypass_follow0 got=%0b exp=0", byp);
    end
    $display("test_bypass done");
  endtask

  task automatic test_count_sat();
    tick(0, 0, 0, 1);
    checks++;
    if (count !== '0) begin
      failures++;
      $display("FAIL count_clear_idle got=%0d exp=0", count);
    end
    for (int k = 1; k <= 28; k++) tick(k == 1, 0, 0, 0);
    checks++;
    if (count !== 4'd15 || dut_vec !== exp_vec()) begin
      failures++;
      $display("FAIL count_sat got count=%0d vec=%h exp count=15 vec=%h", count, dut_vec, exp_vec());
    end
    tick(0, 0, 0, 1);
    checks++;
    if (count !== '0 || rxv !== 1'b1) begin
      failures++;
      $display("FAIL count_clear_prio got count=%0d rxv=%0b exp 0 1", count, rxv);
    end
    tick(0, 0, 0, 0);
    checks++;
    if (count !== 4'd1) begin
      failures++;
      $display("FAIL count_after_clear got=%0d exp=1", count);
    end
    for (int k = 1; k <= 8; k++) tick(0, k == 1, 0, 0);
    $display("test_count_sat done");
  endtask

  task automatic test_reset_mid_fill();
    for (int k = 1; k <= 3; k++) tick(k == 1, 0, 0, 0);
    #3;
    rst = 1;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== 14'h0) begin
      failures++;
      $display("FAIL reset_mid_fill got=%h exp=%h", dut_vec, 14'h0);
    end
    #1;
    rst = 0;
    for (int k = 1; k <= 3; k++) begin
      tick(1, 1, 0, 0);
      checks++;
      if (state !== 2'd0 || enc !== 1'b0 || dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL start_stop_idle cyc=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
    end
    $display("test_reset_mid_fill done");
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      tick($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
    end
    $display("test_random done");
  endtask

  initial begin
    off[0] = 0;
    off[1] = ENC_LAT;
    off[2] = off[1] + SCR_LAT;
    off[3] = off[2] + DESCR_LAT;
    off[4] = off[3] + DEC_LAT;
    test_reset();
    test_start_fill();
    test_stop_drain();
    test_fill_stop();
    test_bypass();
    test_count_sat();
    test_reset_mid_fill();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
